// File: rtl/hps_reset_pkg.sv
// Shared types and constants for the HPS reset request arbiter.
package hps_reset_pkg;

    localparam int CNT_W  = 8;
    localparam int TYPE_W = 3;

    // Bit positions of the request types in every 3-bit request vector
    localparam int COLD  = 0;
    localparam int WARM  = 1;
    localparam int DEBUG = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    // Add a small increment to a statistics counter, sticking at all-ones
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/hps_reset_arbiter_if.sv
// Request inputs, active-low HPS reset requests and statistics of the arbiter.
interface hps_reset_arbiter_if;
    import hps_reset_pkg::*;

    logic [TYPE_W-1:0] probe_req;
    logic [TYPE_W-1:0] btn_req;
    logic              cold_req_n;
    logic              warm_req_n;
    logic              debug_req_n;
    logic              busy;
    logic [CNT_W-1:0]  grant_count;
    logic [CNT_W-1:0]  drop_count;

    // Requester side
    modport master (
        output probe_req, btn_req,
        input  cold_req_n, warm_req_n, debug_req_n, busy, grant_count, drop_count
    );

    // Arbiter side
    modport slave (
        input  probe_req, btn_req,
        output cold_req_n, warm_req_n, debug_req_n, busy, grant_count, drop_count
    );

endinterface

// File: rtl/hps_reset_arbiter_edge_det.sv
// Per-bit rising-edge detector. While reset is held the history register
// tracks the inputs, so a level already high at reset release is not an edge.
module hps_reset_edge_det #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_lvl,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    // Next history value and the edge itself (suppressed during reset)
    always_comb begin
        prev_d = in_lvl;
        rise   = rst ? '0 : (in_lvl & ~prev_q);
    end

    // History register, loaded with the live inputs in reset as well
    always_ff @(posedge clk) begin
        if (rst) prev_q <= in_lvl;
        else     prev_q <= prev_d;
    end

endmodule

// File: rtl/hps_reset_arbiter.sv
// HPS reset request arbiter: merges probe and button reset requests, issues
// one active-low pulse at a time (cold > warm > debug) followed by a guard gap.
// Optional statistics counters are built when HPS_RST_ARB_STATS_EN is defined;
// otherwise grant_count/drop_count read 0.
//
// state    | meaning
// ST_IDLE  | no pulse; grant highest-priority pending or new request
// ST_PULSE | one *_req_n held low, counter runs down the pulse length
// ST_GUARD | all outputs high for GUARD_CYCLES before accepting again
module hps_reset_arbiter
    import hps_reset_pkg::*;
#(
    parameter int COLD_PULSE   = 6,
    parameter int WARM_PULSE   = 2,
    parameter int DEBUG_PULSE  = 32,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    hps_reset_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] COLD_LOAD  = CNT_W'(COLD_PULSE - 1);
    localparam logic [CNT_W-1:0] WARM_LOAD  = CNT_W'(WARM_PULSE - 1);
    localparam logic [CNT_W-1:0] DEBUG_LOAD = CNT_W'(DEBUG_PULSE - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

    logic [TYPE_W-1:0] edge_probe;
    logic [TYPE_W-1:0] edge_btn;
    logic [TYPE_W-1:0] edges;
    logic [TYPE_W-1:0] req_any;
    logic [TYPE_W-1:0] grant_oh;

    state_e            state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [TYPE_W-1:0] active_q,  active_d;
    logic [TYPE_W-1:0] pending_q, pending_d;

    hps_reset_edge_det #(.WIDTH(TYPE_W)) u_edge_probe (
        .clk    (clk),
        .rst    (rst),
        .in_lvl (bus.probe_req),
        .rise   (edge_probe)
    );

    hps_reset_edge_det #(.WIDTH(TYPE_W)) u_edge_btn (
        .clk    (clk),
        .rst    (rst),
        .in_lvl (bus.btn_req),
        .rise   (edge_btn)
    );

    // Same-type edges from both requesters collapse into one request
    always_comb begin
        edges    = edge_probe | edge_btn;
        req_any  = pending_q | edges;
        grant_oh = '0;
        if (req_any[COLD])       grant_oh[COLD]  = 1'b1;
        else if (req_any[WARM])  grant_oh[WARM]  = 1'b1;
        else if (req_any[DEBUG]) grant_oh[DEBUG] = 1'b1;
    end

    // Next state, pulse/guard down-counter and pending request bookkeeping
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_any) begin
                    state_d  = ST_PULSE;
                    active_d = grant_oh;
                    if (grant_oh[COLD]) begin
                        cnt_d     = COLD_LOAD;
                        pending_d = '0;
                    end else begin
                        cnt_d     = grant_oh[WARM] ? WARM_LOAD : DEBUG_LOAD;
                        pending_d = req_any & ~grant_oh;
                    end
                end
            end
            ST_PULSE: begin
                // A re-edge of the type already pulsing is merged, not queued
                pending_d = pending_q | (edges & ~active_q);
                if (cnt_q == '0) begin
                    if (GUARD_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GUARD;
                        cnt_d   = GUARD_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GUARD: begin
                pending_d = pending_q | edges;
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and arbitration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            active_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign bus.cold_req_n  = ~((state_q == ST_PULSE) && active_q[COLD]);
    assign bus.warm_req_n  = ~((state_q == ST_PULSE) && active_q[WARM]);
    assign bus.debug_req_n = ~((state_q == ST_PULSE) && active_q[DEBUG]);
    assign bus.busy        = (state_q != ST_IDLE);

`ifdef HPS_RST_ARB_STATS_EN
    logic [CNT_W-1:0] grant_count_q, grant_count_d;
    logic [CNT_W-1:0] drop_count_q,  drop_count_d;
    logic             grant_inc;
    logic [1:0]       drop_inc;

    // Grants on IDLE->PULSE; drops from cold flushing or same-type merges
    always_comb begin
        grant_inc = (state_q == ST_IDLE) && (|req_any);
        drop_inc  = 2'd0;
        if (grant_inc && grant_oh[COLD])
            drop_inc = {1'b0, req_any[WARM]} + {1'b0, req_any[DEBUG]};
        else if ((state_q == ST_PULSE) && (|(edges & active_q)))
            drop_inc = 2'd1;
        grant_count_d = sat_add(grant_count_q, {1'b0, grant_inc});
        drop_count_d  = sat_add(drop_count_q, drop_inc);
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            grant_count_q <= grant_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign bus.grant_count = grant_count_q;
    assign bus.drop_count  = drop_count_q;
`else
    assign bus.grant_count = '0;
    assign bus.drop_count  = '0;
`endif

endmodule

// File: tb/tb_hps_reset_arbiter.sv
// Self-checking bench for hps_reset_arbiter: directed scenarios plus random
// request traffic, compared each cycle against a timestamp-based model.
module tb_hps_reset_arbiter;

    localparam int COLD_P  = 6;
    localparam int WARM_P  = 2;
    localparam int DEBUG_P = 32;
    localparam int GUARD_P = 16;

`ifdef HPS_RST_ARB_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    hps_reset_arbiter_if bus ();

    hps_reset_arbiter #(
        .COLD_PULSE   (COLD_P),
        .WARM_PULSE   (WARM_P),
        .DEBUG_PULSE  (DEBUG_P),
        .GUARD_CYCLES (GUARD_P)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n        = 0;

    // Model: when the current pulse started, its type, and the first cycle
    // the arbiter is free again; everything else follows from these.
    int         m_start = -1000;
    int         m_type  = 0;
    int         m_free  = 0;
    logic [2:0] m_pend  = '0;
    int         m_grant = 0;
    int         m_drop  = 0;
    logic [2:0] m_pp    = '0;
    logic [2:0] m_bp    = '0;

    int cold_lows, warm_lows, debug_lows, busy_cycles;
    int warm_first, debug_first;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    function automatic int plen(input int t);
        case (t)
            0:       return COLD_P;
            1:       return WARM_P;
            default: return DEBUG_P;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_update(input logic [2:0] p, input logic [2:0] b, input logic r);
        logic [2:0] e;
        logic [2:0] req;
        int         g;
        if (r) begin
            m_pp    = p;
            m_bp    = b;
            m_pend  = '0;
            m_grant = 0;
            m_drop  = 0;
            m_start = -1000;
            m_free  = n + 1;
        end else begin
            e    = (p & ~m_pp) | (b & ~m_bp);
            m_pp = p;
            m_bp = b;
            if (n >= m_free) begin
                req = m_pend | e;
                if (req != 3'b000) begin
                    g       = req[0] ? 0 : (req[1] ? 1 : 2);
                    m_type  = g;
                    m_start = n + 1;
                    m_free  = n + 1 + plen(g) + GUARD_P;
                    m_grant = sat(m_grant + 1);
                    if (g == 0) begin
                        m_drop = sat(m_drop + int'(req[1]) + int'(req[2]));
                        m_pend = '0;
                    end else begin
                        m_pend = req & ~(3'b001 << g);
                    end
                end
            end else if (n < m_start + plen(m_type)) begin
                if (e[m_type]) m_drop = sat(m_drop + 1);
                m_pend = m_pend | (e & ~(3'b001 << m_type));
            end else begin
                m_pend = m_pend | e;
            end
        end
    endtask

    task automatic step(input logic [2:0] p, input logic [2:0] b, input logic r);
        logic pul, bsy;
        int   lows;
        bus.probe_req = p;
        bus.btn_req   = b;
        rst           = r;
        model_update(p, b, r);
        @(posedge clk);
        #1;
        n++;
        pul = (n >= m_start) && (n < m_start + plen(m_type));
        bsy = (n >= m_start) && (n < m_free);
        check("outputs", {bus.cold_req_n, bus.warm_req_n, bus.debug_req_n, bus.busy},
              {!(pul && m_type == 0), !(pul && m_type == 1), !(pul && m_type == 2), bsy});
        check("grant_count", bus.grant_count, STATS_EN ? m_grant : 0);
        check("drop_count",  bus.drop_count,  STATS_EN ? m_drop  : 0);
        lows = int'(!bus.cold_req_n) + int'(!bus.warm_req_n) + int'(!bus.debug_req_n);
        check("one_low_max", (lows <= 1), 1);
        if (!bus.cold_req_n)  cold_lows++;
        if (!bus.warm_req_n)  warm_lows++;
        if (!bus.debug_req_n) debug_lows++;
        if (bus.busy)         busy_cycles++;
        if (!bus.warm_req_n  && warm_first  < 0) warm_first  = n;
        if (!bus.debug_req_n && debug_first < 0) debug_first = n;
    endtask

    task automatic clear_stats();
        cold_lows   = 0;
        warm_lows   = 0;
        debug_lows  = 0;
        busy_cycles = 0;
        warm_first  = -1;
        debug_first = -1;
    endtask

    task automatic idle(input int cycles, input logic [2:0] p, input logic [2:0] b);
        for (int i = 0; i < cycles; i++) step(p, b, 1'b0);
    endtask

    task automatic do_reset();
        step(3'b000, 3'b000, 1'b1);
        step(3'b000, 3'b000, 1'b1);
        step(3'b000, 3'b000, 1'b0);
        clear_stats();
    endtask

    initial begin
        logic [2:0] p;
        logic [2:0] b;
        int         t0;

        bus.probe_req = '0;
        bus.btn_req   = '0;
        clear_stats();

        // Reset state
        do_reset();
        check("rst_outputs", {bus.cold_req_n, bus.warm_req_n, bus.debug_req_n, bus.busy}, 4'b1110);
        check("rst_grant", bus.grant_count, 0);

        // Single cold request: 6 low cycles, 22 busy cycles
        idle(5, 3'b000, 3'b000);
        clear_stats();
        step(3'b001, 3'b000, 1'b0);
        check("cold_latency", bus.cold_req_n, 0);
        idle(29, 3'b001, 3'b000);
        check("cold_len", cold_lows, COLD_P);
        check("cold_busy", busy_cycles, COLD_P + GUARD_P);
        check("cold_grant", bus.grant_count, STATS_EN ? 1 : 0);

        // Cold flushes simultaneous warm and debug
        do_reset();
        step(3'b110, 3'b001, 1'b0);
        idle(80, 3'b110, 3'b001);
        check("flush_cold", cold_lows, COLD_P);
        check("flush_others", warm_lows + debug_lows, 0);
        check("flush_drop", bus.drop_count, STATS_EN ? 2 : 0);
        check("flush_grant", bus.grant_count, STATS_EN ? 1 : 0);

        // Warm then debug three cycles later: served back to back via guard
        do_reset();
        step(3'b000, 3'b010, 1'b0);
        t0 = n;
        idle(2, 3'b000, 3'b010);
        step(3'b000, 3'b110, 1'b0);
        idle(70, 3'b000, 3'b110);
        check("wd_warm_len", warm_lows, WARM_P);
        check("wd_debug_len", debug_lows, DEBUG_P);
        check("wd_warm_start", warm_first, t0);
        check("wd_debug_start", debug_first, t0 + WARM_P + GUARD_P + 1);
        check("wd_drop", bus.drop_count, 0);

        // Re-edge of debug during its own pulse is merged
        do_reset();
        step(3'b100, 3'b000, 1'b0);
        idle(4, 3'b100, 3'b000);
        idle(2, 3'b000, 3'b000);
        idle(80, 3'b100, 3'b000);
        check("merge_len", debug_lows, DEBUG_P);
        check("merge_drop", bus.drop_count, STATS_EN ? 1 : 0);
        check("merge_grant", bus.grant_count, STATS_EN ? 1 : 0);

        // Reset in the third cycle of a cold pulse with the button held high
        do_reset();
        idle(3, 3'b000, 3'b001);
        check("abort_pre", bus.cold_req_n, 0);
        step(3'b000, 3'b001, 1'b1);
        check("abort_out", bus.cold_req_n, 1);
        step(3'b000, 3'b001, 1'b1);
        clear_stats();
        idle(30, 3'b000, 3'b001);
        check("abort_no_pulse", cold_lows + busy_cycles, 0);
        step(3'b000, 3'b000, 1'b0);
        step(3'b000, 3'b001, 1'b0);
        check("abort_repulse", bus.cold_req_n, 0);
        idle(30, 3'b000, 3'b000);

        // 300 warm requests: grant counter sticks at 255
        do_reset();
        for (int k = 0; k < 300; k++) begin
            step(3'b000, 3'b010, 1'b0);
            idle(WARM_P + GUARD_P + 1, 3'b000, 3'b000);
        end
        check("sat_warm_len", warm_lows, 300 * WARM_P);
        check("sat_grant", bus.grant_count, STATS_EN ? 255 : 0);
        check("sat_drop", bus.drop_count, 0);

        // Random traffic with occasional resets
        do_reset();
        p = '0;
        b = '0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) p = p ^ 3'($urandom_range(1, 7));
            if ($urandom_range(0, 7) == 0) b = b ^ 3'($urandom_range(1, 7));
            step(p, b, ($urandom_range(0, 499) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
